axi_bram_slave: RTL and testbench
=================================

AXI_BRAM_SLAVE -- requirements
Module: axi_bram_slave

Interface
REQ-001 Parameter DataBits, default 64, AXI data width; only 64 is supported.
REQ-002 Parameter AddrBits, default 32, AXI address width.
REQ-003 Parameter MemAddrBits, default 14, byte-address width of storage (2^MemAddrBits bytes).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 slv_aw{valid,ready,id[3:0],addr[AddrBits-1:0],len[3:0],size[2:0],lock[1:0],burst[1:0]}  AXI3 write-address channel; ready is out, rest are in.
REQ-007 slv_w{valid,ready,id[3:0],strb[7:0],last,data[63:0]}  AXI3 write-data channel; ready is out.
REQ-008 slv_b{valid,ready,id[3:0],resp[1:0]}  AXI3 write-response channel; bready is in, rest are out.
REQ-009 slv_ar{valid,ready,id,addr,len,size,lock,burst}  AXI3 read-address channel; widths as AW.
REQ-010 slv_r{valid,ready,id[3:0],data[63:0],resp[1:0],last}  AXI3 read-data channel; rready is in, rest are out.

Function
REQ-011 Read and write paths SHALL be independent; one outstanding burst per direction; both MAY run concurrently.
REQ-012 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); AW handshake latches id/addr/len/burst and moves to W_DATA.
REQ-013 Each W beat SHALL write byte lanes whose wstrb bit is 1 at word index addr[MemAddrBits-1:3]; wid is ignored.
REQ-014 Beat address: burst 00 (FIXED) holds; 01 (INCR) and 10 (WRAP, treated as INCR) add 8; word index wraps modulo 2^(MemAddrBits-3).
REQ-015 Burst ends on beat len+1 or on wlast, whichever comes first; bresp=OKAY(00) if wlast coincides with beat len+1, else SLVERR(10); bid=latched awid.
REQ-016 bvalid holds until bready; W_RESP->W_IDLE on handshake; awready reasserts the next cycle.
REQ-017 Read FSM states: R_IDLE (arready=1), R_BURST; AR handshake latches id/addr/len/burst.
REQ-018 RAM read latency is 1 cycle; R outputs SHALL be registered via a 2-entry output buffer; a RAM read is issued only when buffer occupancy plus in-flight reads is below 2.
REQ-019 With rready held high, first rvalid SHALL appear 2 cycles after AR handshake and beats SHALL stream 1/cycle.
REQ-020 rlast=1 on beat len+1 only; rid=latched arid; rresp=OKAY; rvalid/rdata/rlast stable while rvalid & !rready.
REQ-021 Return to R_IDLE after last beat issued to RAM; arready reasserts only when output buffer is empty.
REQ-022 Collision: a write accepted in cycle N SHALL be visible to reads issued in cycle N+1 onward; a same-cycle read returns old data.
REQ-023 awsize/arsize other than 3'b011 SHALL be treated as 3'b011; lock is ignored.

Reset
REQ-024 During rst all outputs SHALL be 0 (awready, wready, bvalid, arready, rvalid, rlast, ids, resp, data).
REQ-025 awready and arready SHALL assert the first cycle after rst deasserts.
REQ-026 rst mid-burst SHALL abort both FSMs with no response issued; memory contents preserved.

Configuration
REQ-027 Macro AXI_BRAM_DECERR_EN: when defined, any beat with addr >= 2^MemAddrBits SHALL not write and SHALL return resp DECERR(11) (B if any beat out-of-range; R per beat, rdata=0).
REQ-028 Without AXI_BRAM_DECERR_EN, upper address bits are ignored (alias modulo memory size) and no DECERR is produced.

Structure
REQ-029 Shared package axi_pkg SHALL hold burst encodings (FIXED/INCR/WRAP) and resp encodings (OKAY/EXOKAY/SLVERR/DECERR).
REQ-030 Storage SHALL be one sub-module ram_sdp_be: simple dual-port RAM, 64-bit, 8 byte enables, registered read.

Verification
REQ-031 AW addr=0x100 len=3 INCR, 4 beats data 0x11..0x44 strb=FF wlast on 4th -> bresp=00, bid=awid; AR same -> 4 beats 0x11..0x44, rlast on 4th, first rvalid 2 cycles after AR.
REQ-032 Read len=15 with rready toggling 1/0 every cycle -> 16 beats, no data lost/duplicated, rdata stable during stall.
REQ-033 Write len=3 with wlast on beat 2 -> burst ends, bresp=10; beat 3 not written.
REQ-034 Strobe 0x0F over preloaded 0xFFFF..FF at 0x200 -> readback 0xFFFFFFFF_<new low word>.
REQ-035 rst asserted mid read burst (beat 2 of 8) -> rvalid=0 next cycle, arready=1 after release, memory unchanged.
REQ-036 With AXI_BRAM_DECERR_EN, AR addr=0x4000 (MemAddrBits=14) -> rresp=11, rdata=0; without macro -> data of addr 0x0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3 encodings for the BRAM slave: burst types and response codes.
package axi_pkg;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axi_bram_slave_if.sv
// AXI3 five-channel bundle between a master and the BRAM slave.
interface axi_bram_slave_if #(
   parameter int unsigned AddrBits = 32,
   parameter int unsigned DataBits = 64
);
   logic                  aw_valid;
   logic                  aw_ready;
   logic [3:0]            aw_id;
   logic [AddrBits-1:0]   aw_addr;
   logic [3:0]            aw_len;
   logic [2:0]            aw_size;
   logic [1:0]            aw_lock;
   logic [1:0]            aw_burst;

   logic                  w_valid;
   logic                  w_ready;
   logic [3:0]            w_id;
   logic [DataBits/8-1:0] w_strb;
   logic                  w_last;
   logic [DataBits-1:0]   w_data;

   logic                  b_valid;
   logic                  b_ready;
   logic [3:0]            b_id;
   logic [1:0]            b_resp;

   logic                  ar_valid;
   logic                  ar_ready;
   logic [3:0]            ar_id;
   logic [AddrBits-1:0]   ar_addr;
   logic [3:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_lock;
   logic [1:0]            ar_burst;

   logic                  r_valid;
   logic                  r_ready;
   logic [3:0]            r_id;
   logic [DataBits-1:0]   r_data;
   logic [1:0]            r_resp;
   logic                  r_last;

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_lock, aw_burst,
      output aw_ready,
      input  w_valid, w_id, w_strb, w_last, w_data,
      output w_ready,
      output b_valid, b_id, b_resp,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_lock, ar_burst,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last,
      input  r_ready
   );

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_lock, aw_burst,
      input  aw_ready,
      output w_valid, w_id, w_strb, w_last, w_data,
      input  w_ready,
      input  b_valid, b_id, b_resp,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_lock, ar_burst,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last,
      output r_ready
   );

endinterface

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
module ram_sdp_be #(
   parameter int unsigned WordBits = 11,
   parameter int unsigned DataBits = 64
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [WordBits-1:0]   waddr,
   input  logic [DataBits/8-1:0] wstrb,
   input  logic [DataBits-1:0]   wdata,
   input  logic                  re,
   input  logic [WordBits-1:0]   raddr,
   output logic [DataBits-1:0]   rdata
);

   localparam int unsigned Depth = 2 ** WordBits;

   logic [DataBits-1:0] mem [Depth];

   // A read and write to the same word in one cycle returns the old contents.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DataBits / 8; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_bram_slave.sv
// AXI3 slave backed by a byte-enabled BRAM; independent read and write burst engines.
// Define AXI_BRAM_DECERR_EN to answer out-of-range beats with DECERR instead of aliasing.
module axi_bram_slave
   import axi_pkg::*;
#(
   parameter int unsigned DataBits    = 64,
   parameter int unsigned AddrBits    = 32,
   parameter int unsigned MemAddrBits = 14
) (
   input logic              clk,
   input logic              rst,
   axi_bram_slave_if.slave  bus
);

   localparam int unsigned WordBits = MemAddrBits - 3;
   localparam int unsigned StrbBits = DataBits / 8;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic {RIdle, RBurst} r_state_e;

   // Next beat address: only the word index advances, so bursts wrap inside the memory.
   function automatic logic [AddrBits-1:0] beat_next(input logic [AddrBits-1:0] addr,
                                                     input logic [1:0]          burst);
      logic [AddrBits-1:0] nxt;
      nxt = addr;
      if (burst != BurstFixed) nxt[MemAddrBits-1:3] = addr[MemAddrBits-1:3] + WordBits'(1);
      return nxt;
   endfunction

   // Write path state
   w_state_e            w_state_q;
   logic                aw_ready_q;
   logic                w_ready_q;
   logic                b_valid_q;
   logic [1:0]          b_resp_q;
   logic [3:0]          aw_id_q;
   logic [AddrBits-1:0] aw_addr_q;
   logic [3:0]          aw_len_q;
   logic [1:0]          aw_burst_q;
   logic [3:0]          w_cnt_q;
   logic                w_dec_q;

   // Read path state
   r_state_e            r_state_q;
   logic                ar_ready_q;
   logic [3:0]          ar_id_q;
   logic [AddrBits-1:0] ar_addr_q;
   logic [3:0]          ar_len_q;
   logic [1:0]          ar_burst_q;
   logic [3:0]          r_cnt_q;
   logic                pend_q;
   logic                pend_last_q;
   logic                pend_dec_q;
   logic [DataBits-1:0] buf_data_q [2];
   logic                buf_last_q [2];
   logic [1:0]          buf_resp_q [2];
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [1:0]          buf_cnt_q;
   logic [1:0]          buf_cnt_d;

   logic                aw_fire;
   logic                w_fire;
   logic                w_end;
   logic                w_len_hit;
   logic                ar_fire;
   logic                r_valid;
   logic                r_pop;
   logic [1:0]          occ;
   logic                rd_issue;
   logic                rd_last;
   logic                w_oob;
   logic                r_oob;

   logic                ram_we;
   logic [WordBits-1:0] ram_waddr;
   logic                ram_re;
   logic [WordBits-1:0] ram_raddr;
   logic [DataBits-1:0] ram_rdata;

`ifdef AXI_BRAM_DECERR_EN
   assign w_oob = |aw_addr_q[AddrBits-1:MemAddrBits];
   assign r_oob = |ar_addr_q[AddrBits-1:MemAddrBits];
`else
   assign w_oob = 1'b0;
   assign r_oob = 1'b0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{bus.aw_size, bus.aw_lock, bus.w_id, bus.ar_size, bus.ar_lock};

   assign aw_fire   = bus.aw_valid & aw_ready_q;
   assign w_fire    = bus.w_valid & w_ready_q;
   assign w_len_hit = (w_cnt_q == aw_len_q);
   assign w_end     = w_len_hit | bus.w_last;
   assign ram_we    = w_fire & ~w_oob;
   assign ram_waddr = aw_addr_q[MemAddrBits-1:3];

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q  <= WIdle;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= RespOkay;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_burst_q <= '0;
         w_cnt_q    <= '0;
         w_dec_q    <= 1'b0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               aw_ready_q <= 1'b1;
               if (aw_fire) begin
                  aw_id_q    <= bus.aw_id;
                  aw_addr_q  <= bus.aw_addr;
                  aw_len_q   <= bus.aw_len;
                  aw_burst_q <= bus.aw_burst;
                  w_cnt_q    <= '0;
                  w_dec_q    <= 1'b0;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  w_state_q  <= WData;
               end
            end
            WData: begin
               if (w_fire) begin
                  aw_addr_q <= beat_next(aw_addr_q, aw_burst_q);
                  w_cnt_q   <= w_cnt_q + 4'd1;
                  w_dec_q   <= w_dec_q | w_oob;
                  if (w_end) begin
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                     w_state_q <= WResp;
                     if (w_dec_q | w_oob)            b_resp_q <= RespDecerr;
                     else if (bus.w_last & w_len_hit) b_resp_q <= RespOkay;
                     else                             b_resp_q <= RespSlverr;
                  end
               end
            end
            WResp: begin
               if (bus.b_ready) begin
                  b_valid_q  <= 1'b0;
                  aw_ready_q <= 1'b1;
                  w_state_q  <= WIdle;
               end
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   // Reads are issued only while the output buffer can still absorb them, counting the
   // beat leaving this cycle so a continuously-ready master streams one beat per cycle.
   assign ar_fire   = bus.ar_valid & ar_ready_q;
   assign r_valid   = (buf_cnt_q != 2'd0);
   assign r_pop     = r_valid & bus.r_ready;
   assign occ       = buf_cnt_q - {1'b0, r_pop} + {1'b0, pend_q};
   assign rd_issue  = (r_state_q == RBurst) && (occ < 2'd2);
   assign rd_last   = (r_cnt_q == ar_len_q);
   assign buf_cnt_d = buf_cnt_q + {1'b0, pend_q} - {1'b0, r_pop};
   assign ram_re    = rd_issue;
   assign ram_raddr = ar_addr_q[MemAddrBits-1:3];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q     <= RIdle;
         ar_ready_q    <= 1'b0;
         ar_id_q       <= '0;
         ar_addr_q     <= '0;
         ar_len_q      <= '0;
         ar_burst_q    <= '0;
         r_cnt_q       <= '0;
         pend_q        <= 1'b0;
         pend_last_q   <= 1'b0;
         pend_dec_q    <= 1'b0;
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_last_q[0] <= 1'b0;
         buf_last_q[1] <= 1'b0;
         buf_resp_q[0] <= RespOkay;
         buf_resp_q[1] <= RespOkay;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         buf_cnt_q     <= '0;
      end else begin
         pend_q      <= rd_issue;
         pend_last_q <= rd_issue & rd_last;
         pend_dec_q  <= r_oob;
         if (pend_q) begin
            buf_data_q[wr_ptr_q] <= pend_dec_q ? '0 : ram_rdata;
            buf_last_q[wr_ptr_q] <= pend_last_q;
            buf_resp_q[wr_ptr_q] <= pend_dec_q ? RespDecerr : RespOkay;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (r_pop) rd_ptr_q <= ~rd_ptr_q;
         buf_cnt_q <= buf_cnt_d;
         unique case (r_state_q)
            RIdle: begin
               ar_ready_q <= (buf_cnt_d == 2'd0);
               if (ar_fire) begin
                  ar_id_q    <= bus.ar_id;
                  ar_addr_q  <= bus.ar_addr;
                  ar_len_q   <= bus.ar_len;
                  ar_burst_q <= bus.ar_burst;
                  r_cnt_q    <= '0;
                  ar_ready_q <= 1'b0;
                  r_state_q  <= RBurst;
               end
            end
            RBurst: begin
               ar_ready_q <= 1'b0;
               if (rd_issue) begin
                  ar_addr_q <= beat_next(ar_addr_q, ar_burst_q);
                  r_cnt_q   <= r_cnt_q + 4'd1;
                  if (rd_last) r_state_q <= RIdle;
               end
            end
            default: r_state_q <= RIdle;
         endcase
      end
   end

   assign bus.aw_ready = aw_ready_q;
   assign bus.w_ready  = w_ready_q;
   assign bus.b_valid  = b_valid_q;
   assign bus.b_id     = aw_id_q;
   assign bus.b_resp   = b_resp_q;
   assign bus.ar_ready = ar_ready_q;
   assign bus.r_valid  = r_valid;
   assign bus.r_id     = ar_id_q;
   assign bus.r_data   = buf_data_q[rd_ptr_q];
   assign bus.r_resp   = buf_resp_q[rd_ptr_q];
   assign bus.r_last   = buf_last_q[rd_ptr_q];

   ram_sdp_be #(
      .WordBits (WordBits),
      .DataBits (DataBits)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wstrb (bus.w_strb[StrbBits-1:0]),
      .wdata (bus.w_data),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_axi_bram_slave.sv
// Self-checking bench for axi_bram_slave against a word-array memory model.
module tb_axi_bram_slave;
   import axi_pkg::*;

   localparam int unsigned AddrBits    = 32;
   localparam int unsigned MemAddrBits = 14;
`ifdef AXI_BRAM_DECERR_EN
   localparam bit DecErr = 1'b1;
`else
   localparam bit DecErr = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_bram_slave_if #(.AddrBits(AddrBits), .DataBits(64)) bus ();

   axi_bram_slave #(
      .DataBits    (64),
      .AddrBits    (AddrBits),
      .MemAddrBits (MemAddrBits)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] model [2048];
   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   int          rbeats, rlat, rstall_err;
   logic [3:0]  rid_got, bid_got;
   logic [1:0]  bresp_got, exp_bresp;
   bit          rto, wto;

   function automatic logic [10:0] beat_idx(input logic [31:0] addr, input logic [1:0] burst,
                                            input int k);
      int idx;
      idx = int'(addr[13:3]) + ((burst == BurstFixed) ? 0 : k);
      return 11'(idx % 2048);
   endfunction

   function automatic bit is_oob(input logic [31:0] addr);
      return DecErr && (addr >= 32'h4000);
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int nbeats);
      int n;
      wto = 1'b0;
      bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst;
      bus.aw_size = 3'($urandom); bus.aw_lock = 2'($urandom); bus.aw_valid = 1'b1;
      n = 0;
      while (!bus.aw_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) wto = 1'b1;
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         bus.w_valid = 1'b1; bus.w_data = wd[k]; bus.w_strb = ws[k];
         bus.w_last = (k == nbeats - 1); bus.w_id = 4'($urandom);
         n = 0;
         while (!bus.w_ready && n < 100) begin @(posedge clk); #1; n++; end
         if (n >= 100) wto = 1'b1;
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0; bus.w_last = 1'b0;
      bus.b_ready = 1'b1;
      n = 0;
      while (!bus.b_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) wto = 1'b1;
      bresp_got = bus.b_resp; bid_got = bus.b_id;
      @(posedge clk); #1;
      bus.b_ready = 1'b0;
      exp_bresp = is_oob(addr) ? RespDecerr : (nbeats == int'(len) + 1) ? RespOkay : RespSlverr;
      if (!is_oob(addr)) begin
         for (int k = 0; k < nbeats; k++)
            for (int b = 0; b < 8; b++)
               if (ws[k][b]) model[beat_idx(addr, burst, k)][8*b +: 8] = wd[k][8*b +: 8];
      end
   endtask

   // mode 0: rready held high, 1: toggles every cycle, 2: random
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int mode);
      int n, hs;
      bit stalled, done;
      logic [63:0] hold_d;
      logic hold_l;
      rbeats = 0; rlat = -1; rstall_err = 0; rto = 1'b0; stalled = 1'b0; done = 1'b0;
      bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst;
      bus.ar_size = 3'($urandom); bus.ar_lock = 2'($urandom); bus.ar_valid = 1'b1;
      n = 0;
      while (!bus.ar_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) rto = 1'b1;
      @(posedge clk); #1;
      bus.ar_valid = 1'b0;
      hs = cyc;
      n = 0;
      while (!done && n < 400) begin
         bus.r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
         if (bus.r_valid) begin
            if (rlat < 0) rlat = cyc - hs;
            if (stalled && (bus.r_data !== hold_d || bus.r_last !== hold_l)) rstall_err++;
            if (bus.r_ready) begin
               if (rbeats < 16) begin
                  rd[rbeats] = bus.r_data; rr[rbeats] = bus.r_resp; rl[rbeats] = bus.r_last;
               end
               rid_got = bus.r_id;
               rbeats++;
               stalled = 1'b0;
               if (bus.r_last) done = 1'b1;
            end else begin
               stalled = 1'b1; hold_d = bus.r_data; hold_l = bus.r_last;
            end
         end else if (stalled) begin
            rstall_err++;
         end
         @(posedge clk); #1;
         n++;
      end
      if (!done) rto = 1'b1;
      bus.r_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last} !== 6'b0)
         begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
            {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last}); end
      n_tests++;
      if ({bus.b_id, bus.r_id, bus.b_resp, bus.r_resp, bus.r_data} !== 76'h0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0",
            {bus.b_id, bus.r_id, bus.b_resp, bus.r_resp, bus.r_data});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.aw_ready, bus.ar_ready} !== 2'b11) begin
         n_fail++; $display("FAIL reset_release_ready: got %b expected 11",
                            {bus.aw_ready, bus.ar_ready});
      end
   endtask

   task automatic test_basic;
      for (int k = 0; k < 4; k++) begin wd[k] = 64'h11 * 64'(k + 1); ws[k] = 8'hFF; end
      do_write(4'h5, 32'h100, 4'd3, BurstIncr, 4);
      n_tests++;
      if ({wto, bresp_got, bid_got} !== {1'b0, RespOkay, 4'h5}) begin
         n_fail++; $display("FAIL basic_bresp: got to=%0d resp=%0d id=%0h expected 0 0 5",
                            wto, bresp_got, bid_got);
      end
      do_read(4'h9, 32'h100, 4'd3, BurstIncr, 0);
      n_tests++;
      if ({rto, rbeats, rlat, rid_got} !== {1'b0, 32'd4, 32'd2, 4'h9}) begin
         n_fail++; $display("FAIL basic_read_shape: got to=%0d beats=%0d lat=%0d id=%0h expected 0 4 2 9",
                            rto, rbeats, rlat, rid_got);
      end
      for (int k = 0; k < 4 && k < rbeats; k++) begin
         n_tests++;
         if ({rd[k], rr[k], rl[k]} !== {64'h11 * 64'(k + 1), RespOkay, k == 3}) begin
            n_fail++; $display("FAIL basic_beat%0d: got %h/%0d/%0d expected %h/0/%0d",
                               k, rd[k], rr[k], rl[k], 64'h11 * 64'(k + 1), k == 3);
         end
      end
   endtask

   task automatic test_rready_toggle;
      for (int k = 0; k < 16; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
      do_write(4'h1, 32'h800, 4'd15, BurstIncr, 16);
      do_read(4'h2, 32'h800, 4'd15, BurstIncr, 1);
      n_tests++;
      if ({rto, rbeats, rstall_err} !== {1'b0, 32'd16, 32'd0}) begin
         n_fail++; $display("FAIL toggle_shape: got to=%0d beats=%0d stall_err=%0d expected 0 16 0",
                            rto, rbeats, rstall_err);
      end
      for (int k = 0; k < 16 && k < rbeats; k++) begin
         n_tests++;
         if ({rd[k], rl[k]} !== {model[beat_idx(32'h800, BurstIncr, k)], k == 15}) begin
            n_fail++; $display("FAIL toggle_beat%0d: got %h/%0d expected %h/%0d", k, rd[k], rl[k],
                               model[beat_idx(32'h800, BurstIncr, k)], k == 15);
         end
      end
   endtask

   task automatic test_early_last;
      for (int k = 0; k < 4; k++) begin wd[k] = 64'hDEAD_BEEF_0000_0000 | 64'(k); ws[k] = 8'hFF; end
      do_write(4'h3, 32'hA00, 4'd3, BurstIncr, 4);
      for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
      do_write(4'h3, 32'hA00, 4'd3, BurstIncr, 3);
      n_tests++;
      if ({wto, bresp_got} !== {1'b0, RespSlverr} || exp_bresp !== RespSlverr) begin
         n_fail++; $display("FAIL early_last_bresp: got %0d expected 2", bresp_got);
      end
      do_read(4'h4, 32'hA00, 4'd3, BurstIncr, 0);
      n_tests++;
      if (rd[3] !== 64'hDEAD_BEEF_0000_0003) begin
         n_fail++; $display("FAIL early_last_beat3: got %h expected deadbeef00000003", rd[3]);
      end
      n_tests++;
      if ({rd[0], rd[2]} !== {model[beat_idx(32'hA00, BurstIncr, 0)],
                              model[beat_idx(32'hA00, BurstIncr, 2)]}) begin
         n_fail++; $display("FAIL early_last_data: got %h %h", rd[0], rd[2]);
      end
   endtask

   task automatic test_strobe;
      wd[0] = '1; ws[0] = 8'hFF;
      do_write(4'h2, 32'h200, 4'd0, BurstIncr, 1);
      wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'h0F;
      do_write(4'h2, 32'h200, 4'd0, BurstIncr, 1);
      do_read(4'h2, 32'h200, 4'd0, BurstIncr, 0);
      n_tests++;
      if (rd[0] !== 64'hFFFF_FFFF_89AB_CDEF || model[64] !== 64'hFFFF_FFFF_89AB_CDEF) begin
         n_fail++; $display("FAIL strobe_low: got %h expected ffffffff89abcdef", rd[0]);
      end
   endtask

   task automatic test_random;
      logic [31:0] addr;
      logic [3:0]  len, id;
      logic [1:0]  burst;
      for (int it = 0; it < 10; it++) begin
         addr = 32'($urandom_range(0, 2047)) << 3;
         len = 4'($urandom); burst = 2'($urandom_range(0, 2)); id = 4'($urandom);
         for (int k = 0; k < 16; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
         do_write(id, addr, len, burst, int'(len) + 1);
         n_tests++;
         if ({wto, bresp_got, bid_got} !== {1'b0, exp_bresp, id}) begin
            n_fail++; $display("FAIL rand%0d_b: got resp=%0d id=%0h expected %0d %0h",
                               it, bresp_got, bid_got, exp_bresp, id);
         end
         do_read(~id, addr, len, burst, 2);
         n_tests++;
         if ({rto, rbeats, rstall_err, rid_got} !== {1'b0, int'(len) + 1, 32'd0, ~id}) begin
            n_fail++; $display("FAIL rand%0d_shape: got beats=%0d stall=%0d id=%0h expected %0d 0 %0h",
                               it, rbeats, rstall_err, rid_got, int'(len) + 1, ~id);
         end
         for (int k = 0; k <= int'(len) && k < rbeats; k++) begin
            n_tests++;
            if ({rd[k], rr[k], rl[k]} !== {model[beat_idx(addr, burst, k)], RespOkay,
                                           k == int'(len)}) begin
               n_fail++; $display("FAIL rand%0d_beat%0d: got %h/%0d/%0d expected %h", it, k, rd[k],
                                  rr[k], rl[k], model[beat_idx(addr, burst, k)]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int n, got;
      for (int k = 0; k < 8; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
      do_write(4'h7, 32'h300, 4'd7, BurstIncr, 8);
      bus.ar_id = 4'h4; bus.ar_addr = 32'h300; bus.ar_len = 4'd7; bus.ar_burst = BurstIncr;
      bus.ar_valid = 1'b1;
      n = 0;
      while (!bus.ar_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
      got = 0; n = 0;
      while (got < 2 && n < 100) begin
         if (bus.r_valid) got++;
         @(posedge clk); #1; n++;
      end
      rst = 1'b1; bus.r_ready = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({got, bus.r_valid} !== {32'd2, 1'b0}) begin
         n_fail++; $display("FAIL midrst_rvalid: got beats=%0d rvalid=%0d expected 2 0",
                            got, bus.r_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.ar_ready, bus.aw_ready, bus.r_valid} !== 3'b110) begin
         n_fail++; $display("FAIL midrst_release: got %b expected 110",
                            {bus.ar_ready, bus.aw_ready, bus.r_valid});
      end
      do_read(4'h4, 32'h300, 4'd7, BurstIncr, 0);
      for (int k = 0; k < 8 && k < rbeats; k++) begin
         n_tests++;
         if (rd[k] !== model[beat_idx(32'h300, BurstIncr, k)]) begin
            n_fail++; $display("FAIL midrst_mem%0d: got %h expected %h", k, rd[k],
                               model[beat_idx(32'h300, BurstIncr, k)]);
         end
      end
   endtask

   task automatic test_alias;
      wd[0] = 64'hA5A5_5A5A_0F0F_F0F0; ws[0] = 8'hFF;
      do_write(4'h6, 32'h0, 4'd0, BurstIncr, 1);
      do_read(4'h7, 32'h4000, 4'd0, BurstIncr, 0);
      n_tests++;
      if ({rd[0], rr[0]} !== (DecErr ? {64'h0, RespDecerr} : {64'hA5A5_5A5A_0F0F_F0F0, RespOkay}))
         begin n_fail++; $display("FAIL alias_read: got %h/%0d", rd[0], rr[0]); end
      wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
      do_write(4'h6, 32'h4008, 4'd0, BurstIncr, 1);
      n_tests++;
      if (bresp_got !== exp_bresp) begin
         n_fail++; $display("FAIL alias_bresp: got %0d expected %0d", bresp_got, exp_bresp);
      end
      do_read(4'h7, 32'h8, 4'd0, BurstIncr, 0);
      n_tests++;
      if (rd[0] !== model[1]) begin
         n_fail++; $display("FAIL alias_write: got %h expected %h", rd[0], model[1]);
      end
   endtask

   initial begin
      bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
      bus.aw_size = '0; bus.aw_lock = '0; bus.aw_burst = '0;
      bus.w_valid = 1'b0; bus.w_id = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_data = '0;
      bus.b_ready = 1'b0;
      bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
      bus.ar_size = '0; bus.ar_lock = '0; bus.ar_burst = '0;
      bus.r_ready = 1'b0;
      test_reset();
      test_basic();
      test_rready_toggle();
      test_early_last();
      test_strobe();
      test_random();
      test_reset_mid_burst();
      test_alias();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
